bmem_arbiter: RTL and testbench
===============================

// Module: bmem_arbiter
// PURPOSE
// - Parametrised N-port arbiter that shares one burst-memory (bmem) port between NUM_PORTS cache/memory units.
// - Generalises the fixed two-core (OoO + pipeline) memory sharing to any core count.
// - Sits between the per-core memory units and the single bmem/FPGA memory controller.
// - Provides round-robin grant, write-burst locking and in-order read-response routing.
// PARAMETERS
// - NUM_PORTS        2   number of requesters (>=2)
// - ADDR_WIDTH       32  bmem address width
// - DATA_WIDTH       64  bmem beat width
// - BURST_LEN        4   beats per read response / write burst (>=1)
// - MAX_OUTSTANDING  4   max reads in flight (depth of ID FIFO, power of 2)
// PORTS
// - clk         in   1                     clock
// - rst         in   1                     synchronous, active-high reset
// - req_addr    in   [NUM_PORTS][ADDR_WIDTH]  per-port request address
// - req_read    in   [NUM_PORTS]           per-port read request
// - req_write   in   [NUM_PORTS]           per-port write beat valid
// - req_wdata   in   [NUM_PORTS][DATA_WIDTH]  per-port write beat
// - req_ready   out  [NUM_PORTS]           request/beat accepted this cycle
// - req_raddr   out  [NUM_PORTS][ADDR_WIDTH]  broadcast of bmem_raddr
// - req_rdata   out  [NUM_PORTS][DATA_WIDTH]  broadcast of bmem_rdata
// - req_rvalid  out  [NUM_PORTS]           read beat valid, one-hot to owner
// - bmem_addr   out  ADDR_WIDTH            muxed address
// - bmem_read   out  1                     muxed read
// - bmem_write  out  1                     muxed write
// - bmem_wdata  out  DATA_WIDTH            muxed write data
// - bmem_ready  in   1                     memory accepts request/beat
// - bmem_raddr  in   ADDR_WIDTH            address of returning read
// - bmem_rdata  in   DATA_WIDTH            read beat
// - bmem_rvalid in   1                     read beat valid; responses arrive in request order
// - orphan_err  out  1                     sticky: rvalid seen with ID FIFO empty
// BEHAVIOUR
// - Reset (sync):
//   - state=IDLE; rr pointer=0; beat counters=0; FIFO empty; orphan_err=0.
//   - All req_ready/req_rvalid=0 and bmem_read/bmem_write=0 in the reset cycle.
//   - In-flight bursts and responses are abandoned.
// - Transfer rule: a transfer occurs when bmem_ready && (bmem_read || bmem_write).
//   - req_ready[g] = bmem_ready && (g is the selected port) && its request is eligible.
//   - Combinational path; zero added latency on the request path.
// - IDLE:
//   - Eligible[i] = req_write[i] || (req_read[i] && !fifo_full).
//   - Winner = first eligible port searching from rr pointer upward, wrapping modulo NUM_PORTS.
//   - bmem_* driven from the winner; write has priority over read when a port asserts both.
//   - No eligible port: bmem_read=bmem_write=0; bmem_addr/bmem_wdata don't-care (drive winner-0 mux).
// - Read accepted: push winner ID into FIFO; rr pointer = winner+1; stay IDLE.
// - Write accepted:
//   - BURST_LEN==1: rr pointer = winner+1; stay IDLE.
//   - Otherwise: lock the winner, set wbeat=1, go to WBURST.
// - WBURST:
//   - Only the locked port is muxed; it may only write (its req_read is ignored).
//   - Each accepted beat increments wbeat.
//   - When wbeat reaches BURST_LEN-1 and that beat is accepted: state=IDLE, rr pointer = locked+1.
//   - Locked port deasserting write stalls the burst; no timeout.
// - Response path:
//   - req_rvalid[fifo_head] = bmem_rvalid, combinational; all other req_rvalid=0.
//   - rbeat counts beats; on beat BURST_LEN-1: pop FIFO, rbeat=0.
//   - bmem_rvalid with FIFO empty: beat dropped, orphan_err set (cleared only by rst).
// - FIFO full/empty:
//   - fifo_full blocks new read grants even if a pop happens the same cycle.
//   - Push and pop in the same cycle (not full) are both honoured; count unchanged.
// - Widths: ID width = $clog2(NUM_PORTS); count width = $clog2(MAX_OUTSTANDING)+1.
//   - Pointers wrap modulo MAX_OUTSTANDING.
// STRUCTURE
// - Package bmem_arb_pkg:
//   - arb_state_t enum {IDLE, WBURST}.
//   - Helper functions: id width, next round-robin index.
// - Sub-module bmem_arb_id_fifo: sync FIFO of port IDs (push/pop/full/empty/head), depth MAX_OUTSTANDING.
// - Top: RR select (combinational), grant FSM, write beat counter, read beat counter, output muxes.
// TESTING
// - T1 single read: N=2, port1 read addr 0x100, bmem_ready=1.
//   - Expect: bmem_read=1/addr 0x100 same cycle, req_ready[1]=1.
//   - 4 rvalid beats appear only on req_rvalid[1]; FIFO empty afterwards.
// - T2 fairness: both ports hold read continuously, ready=1.
//   - Expect grants 0,1,0,1 on successive cycles, starting at port 0 after reset.
// - T3 write lock: port0 writes 4 beats with ready toggling 1,0,1,1,1 while port1 requests reads.
//   - Expect: no port1 grant until port0's 4th beat is accepted, then port1 granted next cycle.
// - T4 FIFO full: 4 reads accepted with no rvalid.
//   - Expect: 5th read held (req_ready=0) until the first response's 4th beat pops, then granted the cycle after.
// - T5 ordering: N=4, reads from ports 2,0,3; memory returns 12 in-order beats.
//   - Expect rvalid routed 4x port2, 4x port0, 4x port3.
// - T6 reset/orphan: rst asserted mid write burst and with 2 reads outstanding.
//   - Expect all outputs 0 next cycle.
//   - A subsequent stray rvalid sets orphan_err=1 and no req_rvalid.

Source files
------------

// File: rtl/bmem_arb_pkg.sv
// Shared types and helpers for the N-port bmem arbiter.
package bmem_arb_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      WBURST = 1'b1
   } arb_state_t;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? unsigned'($clog2(n)) : 1;
   endfunction

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/bmem_arb_id_fifo.sv
// Synchronous FIFO of requester IDs tracking in-flight reads in issue order.
module bmem_arb_id_fifo
   import bmem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ID_W  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic [ID_W-1:0] push_id,
   input  logic            pop,
   output logic            full,
   output logic            empty,
   output logic [ID_W-1:0] head
);

   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(DEPTH) + 1;

   logic [ID_W-1:0] mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;
   logic            do_push;
   logic            do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNTW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_id;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter sharing one burst-memory port between NUM_PORTS requesters,
// with write-burst locking and in-order read-response routing.
module bmem_arbiter
   import bmem_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS       = 2,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned BURST_LEN       = 4,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_PORTS-1:0]                  req_read,
   input  logic [NUM_PORTS-1:0]                  req_write,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]                  req_ready,
   output logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_raddr,
   output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_rdata,
   output logic [NUM_PORTS-1:0]                  req_rvalid,
   output logic [ADDR_WIDTH-1:0]                 bmem_addr,
   output logic                                  bmem_read,
   output logic                                  bmem_write,
   output logic [DATA_WIDTH-1:0]                 bmem_wdata,
   input  logic                                  bmem_ready,
   input  logic [ADDR_WIDTH-1:0]                 bmem_raddr,
   input  logic [DATA_WIDTH-1:0]                 bmem_rdata,
   input  logic                                  bmem_rvalid,
   output logic                                  orphan_err
);

   localparam int unsigned IDW = id_width(NUM_PORTS);
   localparam int unsigned BW  = $clog2(BURST_LEN + 1);

   arb_state_t       state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   locked;
   logic [BW-1:0]    wbeat;
   logic [BW-1:0]    rbeat;

   logic [NUM_PORTS-1:0] eligible;
   logic [IDW-1:0]       sel;
   logic                 found;
   logic                 sel_write;
   logic                 xfer;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [IDW-1:0]       fifo_head;
   logic                 fifo_push;
   logic                 fifo_pop;
   int unsigned          idx;

   assign eligible = req_write | (req_read & {NUM_PORTS{!fifo_full}});

   // WBURST pins the mux to the locked port and ignores its read request.
   always_comb begin
      sel       = '0;
      found     = 1'b0;
      sel_write = 1'b0;
      idx       = 0;
      if (state == WBURST) begin
         sel       = locked;
         found     = req_write[locked];
         sel_write = 1'b1;
      end else begin
         for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_PORTS;
            if (!found && eligible[IDW'(idx)]) begin
               sel   = IDW'(idx);
               found = 1'b1;
            end
         end
         sel_write = req_write[sel];
      end
   end

   assign bmem_addr  = req_addr[sel];
   assign bmem_wdata = req_wdata[sel];
   assign bmem_write = !rst && found && sel_write;
   assign bmem_read  = !rst && found && !sel_write;
   assign xfer       = bmem_ready && (bmem_read || bmem_write);
   assign fifo_push  = xfer && bmem_read;
   assign fifo_pop   = !rst && bmem_rvalid && !fifo_empty && (rbeat == BW'(BURST_LEN - 1));

   always_comb begin
      req_ready  = '0;
      req_rvalid = '0;
      if (!rst && bmem_ready && found)
         req_ready[sel] = 1'b1;
      if (!rst && bmem_rvalid && !fifo_empty)
         req_rvalid[fifo_head] = 1'b1;
   end

   always_comb begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         req_raddr[p] = bmem_raddr;
         req_rdata[p] = bmem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         locked <= '0;
         wbeat  <= '0;
      end else if (xfer) begin
         case (state)
            IDLE: begin
               if (bmem_write) begin
                  if (BURST_LEN == 1) begin
                     rr_ptr <= IDW'(rr_next(32'(sel), NUM_PORTS));
                  end else begin
                     locked <= sel;
                     wbeat  <= BW'(1);
                     state  <= WBURST;
                  end
               end else begin
                  rr_ptr <= IDW'(rr_next(32'(sel), NUM_PORTS));
               end
            end
            WBURST: begin
               if (wbeat == BW'(BURST_LEN - 1)) begin
                  wbeat  <= '0;
                  state  <= IDLE;
                  rr_ptr <= IDW'(rr_next(32'(locked), NUM_PORTS));
               end else begin
                  wbeat <= wbeat + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rbeat      <= '0;
         orphan_err <= 1'b0;
      end else if (bmem_rvalid) begin
         if (fifo_empty)
            orphan_err <= 1'b1;
         else if (rbeat == BW'(BURST_LEN - 1))
            rbeat <= '0;
         else
            rbeat <= rbeat + 1'b1;
      end
   end

   bmem_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .ID_W  (IDW)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .push_id (sel),
      .pop     (fifo_pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

endmodule

// File: tb/tb_bmem_arbiter.sv
// Self-checking bench for bmem_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_bmem_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int BL = 4;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0][AW-1:0] req_addr;
   logic [N-1:0]         req_read;
   logic [N-1:0]         req_write;
   logic [N-1:0][DW-1:0] req_wdata;
   logic [N-1:0]         req_ready;
   logic [N-1:0][AW-1:0] req_raddr;
   logic [N-1:0][DW-1:0] req_rdata;
   logic [N-1:0]         req_rvalid;
   logic [AW-1:0]        bmem_addr;
   logic                 bmem_read;
   logic                 bmem_write;
   logic [DW-1:0]        bmem_wdata;
   logic                 bmem_ready;
   logic [AW-1:0]        bmem_raddr;
   logic [DW-1:0]        bmem_rdata;
   logic                 bmem_rvalid;
   logic                 orphan_err;

   bmem_arbiter #(
      .NUM_PORTS       (N),
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .BURST_LEN       (BL),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_addr    (req_addr),
      .req_read    (req_read),
      .req_write   (req_write),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .req_raddr   (req_raddr),
      .req_rdata   (req_rdata),
      .req_rvalid  (req_rvalid),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid),
      .orphan_err  (orphan_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: owners of outstanding reads as a queue, plus burst bookkeeping.
   int m_owners[$];
   int m_rr, m_lp, m_wdone, m_rbeats;
   bit m_locked, m_orphan;

   logic [N-1:0] obs_ready, obs_rvalid;
   logic         obs_rd, obs_wr, obs_orphan;
   logic [AW-1:0] obs_addr;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owners.delete();
      m_rr = 0; m_lp = 0; m_wdone = 0; m_rbeats = 0;
      m_locked = 0; m_orphan = 0;
   endtask

   task automatic step();
      int sel, bp;
      bit found, ew, er;
      logic [N-1:0] eready, ervalid;
      @(negedge clk);
      found = 0; sel = 0;
      if (m_locked) begin
         sel = m_lp;
         found = req_write[m_lp];
      end else begin
         for (int k = 0; k < N; k++) begin
            int p;
            p = (m_rr + k) % N;
            if (!found && (req_write[p] || (req_read[p] && m_owners.size() < MO))) begin
               sel = p;
               found = 1;
            end
         end
      end
      if (rst) found = 0;
      ew = found && (m_locked || req_write[sel]);
      er = found && !ew;
      eready = '0;
      if (found && bmem_ready) eready[sel] = 1'b1;
      ervalid = '0;
      if (!rst && bmem_rvalid && m_owners.size() > 0) ervalid[m_owners[0]] = 1'b1;

      check_eq("bmem_read", 64'(bmem_read), 64'(er));
      check_eq("bmem_write", 64'(bmem_write), 64'(ew));
      if (er || ew) check_eq("bmem_addr", 64'(bmem_addr), 64'(req_addr[sel]));
      if (ew) check_eq("bmem_wdata", bmem_wdata, req_wdata[sel]);
      check_eq("req_ready", 64'(req_ready), 64'(eready));
      check_eq("req_rvalid", 64'(req_rvalid), 64'(ervalid));
      check_eq("orphan_err", 64'(orphan_err), 64'(m_orphan));
      bp = cyc % N;
      check_eq("rdata_bcast", req_rdata[bp], bmem_rdata);
      check_eq("raddr_bcast", 64'(req_raddr[bp]), 64'(bmem_raddr));

      obs_ready = req_ready; obs_rvalid = req_rvalid;
      obs_rd = bmem_read; obs_wr = bmem_write; obs_orphan = orphan_err; obs_addr = bmem_addr;

      if (rst) begin
         model_reset();
      end else begin
         if (bmem_rvalid) begin
            if (m_owners.size() == 0) m_orphan = 1;
            else begin
               m_rbeats++;
               if (m_rbeats == BL) begin
                  void'(m_owners.pop_front());
                  m_rbeats = 0;
               end
            end
         end
         if (found && bmem_ready) begin
            if (m_locked) begin
               m_wdone++;
               if (m_wdone == BL) begin
                  m_locked = 0;
                  m_rr = (m_lp + 1) % N;
               end
            end else if (ew) begin
               if (BL == 1) m_rr = (sel + 1) % N;
               else begin
                  m_locked = 1; m_lp = sel; m_wdone = 1;
               end
            end else begin
               m_owners.push_back(sel);
               m_rr = (sel + 1) % N;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_inputs();
      req_read = '0; req_write = '0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
      for (int p = 0; p < N; p++) begin
         req_addr[p]  = $urandom;
         req_wdata[p] = {$urandom, $urandom};
      end
      bmem_raddr = $urandom;
      bmem_rdata = {$urandom, $urandom};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      rst = 1'b0;
   endtask

   task automatic beat(input bit rv);
      bmem_rvalid = rv;
      bmem_raddr  = $urandom;
      bmem_rdata  = {$urandom, $urandom};
   endtask

   task automatic drain(input int beats);
      req_read = '0; req_write = '0;
      for (int i = 0; i < beats; i++) begin
         beat(1'b1);
         step();
      end
      beat(1'b0);
   endtask

   initial begin
      int order[3];
      bit rdy_seq[5];
      model_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      step();
      check_eq("reset_ready", 64'(obs_ready), 64'(0));
      check_eq("reset_rw", 64'({obs_rd, obs_wr}), 64'(0));
      rst = 1'b0;

      // T1: single read from port 1
      req_read[1] = 1'b1; req_addr[1] = 32'h100; bmem_ready = 1'b1;
      step();
      check_eq("t1_ready", 64'(obs_ready), 64'(4'b0010));
      check_eq("t1_addr", 64'(obs_addr), 64'h100);
      check_eq("t1_read", 64'(obs_rd), 64'(1));
      req_read = '0;
      for (int i = 0; i < BL; i++) begin
         beat(1'b1);
         step();
         check_eq("t1_rvalid", 64'(obs_rvalid), 64'(4'b0010));
      end
      beat(1'b0);
      step();

      // T2: fairness between ports 0 and 1 until the FIFO fills
      do_reset();
      req_read = 4'b0011; bmem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("t2_grant", 64'(obs_ready), 64'((i % 2) ? 4'b0010 : 4'b0001));
      end
      step();
      check_eq("t2_full_hold", 64'(obs_ready), 64'(0));
      drain(4 * BL);

      // T3: write burst lock with stalled beat
      do_reset();
      rdy_seq = '{1, 0, 1, 1, 1};
      req_write[0] = 1'b1; req_read[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bmem_ready = rdy_seq[i];
         req_wdata[0] = {$urandom, $urandom};
         step();
         check_eq("t3_no_p1", 64'(obs_ready[1]), 64'(0));
         check_eq("t3_wr", 64'(obs_wr), 64'(1));
      end
      req_write[0] = 1'b0; bmem_ready = 1'b1;
      step();
      check_eq("t3_p1_grant", 64'(obs_ready), 64'(4'b0010));
      drain(BL);

      // T4: FIFO full holds the fifth read until the first response completes
      do_reset();
      req_read[0] = 1'b1; bmem_ready = 1'b1;
      for (int i = 0; i < MO; i++) begin
         step();
         check_eq("t4_accept", 64'(obs_ready), 64'(4'b0001));
      end
      for (int i = 0; i < BL; i++) begin
         beat(1'b1);
         step();
         check_eq("t4_held", 64'(obs_ready), 64'(0));
      end
      beat(1'b0);
      step();
      check_eq("t4_regrant", 64'(obs_ready), 64'(4'b0001));
      drain(MO * BL);

      // T5: response routing follows issue order
      do_reset();
      order = '{2, 0, 3};
      bmem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_read = '0;
         req_read[order[i]] = 1'b1;
         step();
      end
      req_read = '0;
      for (int i = 0; i < 3 * BL; i++) begin
         beat(1'b1);
         step();
         check_eq("t5_route", 64'(obs_rvalid), 64'(1 << order[i / BL]));
      end
      beat(1'b0);

      // T6: reset mid-burst with reads outstanding, then a stray beat
      do_reset();
      bmem_ready = 1'b1;
      req_read = 4'b0001; step();
      req_read = 4'b0100; step();
      req_read = '0; req_write[3] = 1'b1;
      step(); step();
      rst = 1'b1; beat(1'b1);
      step();
      check_eq("t6_rst_out", 64'({obs_ready, obs_rvalid, obs_rd, obs_wr}), 64'(0));
      rst = 1'b0; clear_inputs();
      step();
      check_eq("t6_post_out", 64'({obs_ready, obs_rvalid, obs_rd, obs_wr, obs_orphan}), 64'(0));
      beat(1'b1);
      step();
      check_eq("t6_stray_rv", 64'(obs_rvalid), 64'(0));
      beat(1'b0);
      step();
      check_eq("t6_orphan", 64'(obs_orphan), 64'(1));

      // Random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 149) == 0);
         for (int p = 0; p < N; p++) begin
            req_read[p]  = ($urandom_range(0, 2) == 0);
            req_write[p] = ($urandom_range(0, 4) == 0);
            req_addr[p]  = $urandom;
            req_wdata[p] = {$urandom, $urandom};
         end
         bmem_ready = ($urandom_range(0, 3) != 0);
         beat((m_owners.size() > 0) && ($urandom_range(0, 1) == 1));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
